// File: rtl/ex_lsu.sv
// Execute-stage load/store unit driving an SRAM-like bus, one outstanding access at a time.
// Optional misalignment exceptions are enabled by defining LSU_ALIGN_CHECK_EN.
module ex_lsu #(
    parameter int ADDR_W  = 32,
    parameter int MEMOP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_valid_i,
    input  logic [MEMOP_W-1:0] lsu_memop_i,
    input  logic [ADDR_W-1:0]  lsu_addr_i,
    input  logic [31:0]        lsu_wdata_i,
    input  logic               lsu_flush_i,
    input  logic               mem_addr_ok_i,
    input  logic               mem_data_ok_i,
    input  logic [31:0]        mem_rdata_i,
    output logic               mem_req_o,
    output logic               mem_wr_o,
    output logic [3:0]         mem_be_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    output logic               lsu_stallreq_o,
    output logic               lsu_rvalid_o,
    output logic [31:0]        lsu_rdata_o,
    output logic               lsu_adel_o,
    output logic               lsu_ades_o,
    output logic [ADDR_W-1:0]  lsu_badvaddr_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CANCEL} state_t;

    state_t               state_q, state_d;
    logic [MEMOP_W-1:0]   memop_q, memop_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 addr_error;
    logic                 start;
    logic                 in_req;
    logic                 cap_is_load;
    logic                 cap_is_store;
    logic                 req_is_load;
    logic                 req_is_store;

    function automatic logic [31:0] load_ext(input logic [MEMOP_W-1:0] op,
                                             input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        load_ext = w;
        if (op[0])      load_ext = {{24{b[7]}}, b};
        else if (op[1]) load_ext = {24'd0, b};
        else if (op[2]) load_ext = {{16{h[15]}}, h};
        else if (op[3]) load_ext = {16'd0, h};
    endfunction

    assign req_is_load  = |lsu_memop_i[4:0];
    assign req_is_store = |lsu_memop_i[7:5];
    assign cap_is_load  = |memop_q[4:0];
    assign cap_is_store = |memop_q[7:5];

`ifdef LSU_ALIGN_CHECK_EN
    logic               adel_q, ades_q;
    logic [ADDR_W-1:0]  badvaddr_q;
    logic               exc_take;

    assign addr_error = ((lsu_memop_i[2] | lsu_memop_i[3] | lsu_memop_i[6]) & lsu_addr_i[0])
                      | ((lsu_memop_i[4] | lsu_memop_i[7]) & (|lsu_addr_i[1:0]));
    assign exc_take   = (state_q == S_IDLE) & lsu_valid_i & ~lsu_flush_i & addr_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            adel_q <= exc_take & req_is_load;
            ades_q <= exc_take & req_is_store;
            if (exc_take) badvaddr_q <= lsu_addr_i;
        end
    end

    assign lsu_adel_o     = adel_q;
    assign lsu_ades_o     = ades_q;
    assign lsu_badvaddr_o = badvaddr_q;
`else
    assign addr_error     = 1'b0;
    assign lsu_adel_o     = 1'b0;
    assign lsu_ades_o     = 1'b0;
    assign lsu_badvaddr_o = '0;
`endif

    assign start  = (state_q == S_IDLE) & lsu_valid_i & (|lsu_memop_i) & ~lsu_flush_i & ~addr_error;
    assign in_req = (state_q == S_REQ);

    always_comb begin
        state_d        = state_q;
        memop_d        = memop_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rvalid_d       = 1'b0;
        rdata_d        = rdata_q;
        lsu_stallreq_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                lsu_stallreq_o = start;
                if (start) begin
                    state_d = S_REQ;
                    memop_d = lsu_memop_i;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                end
            end
            S_REQ: begin
                lsu_stallreq_o = 1'b1;
                // A flushed request already accepted by the bus must still drain its response.
                if (lsu_flush_i)        state_d = mem_addr_ok_i ? S_CANCEL : S_IDLE;
                else if (mem_addr_ok_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                lsu_stallreq_o = ~mem_data_ok_i;
                if (mem_data_ok_i) begin
                    state_d = S_IDLE;
                    if (!lsu_flush_i && cap_is_load) begin
                        rvalid_d = 1'b1;
                        rdata_d  = load_ext(memop_q, addr_q[1:0], mem_rdata_i);
                    end
                end else if (lsu_flush_i) begin
                    state_d = S_CANCEL;
                end
            end
            S_CANCEL: begin
                lsu_stallreq_o = lsu_valid_i & (|lsu_memop_i);
                if (mem_data_ok_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = in_req;
        mem_wr_o    = in_req & cap_is_store;
        mem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = 32'd0;
        if (in_req) begin
            if (memop_q[5]) begin
                mem_be_o    = 4'b0001 << addr_q[1:0];
                mem_wdata_o = {4{wdata_q[7:0]}};
            end else if (memop_q[6]) begin
                mem_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
                mem_wdata_o = {2{wdata_q[15:0]}};
            end else if (memop_q[7]) begin
                mem_be_o    = 4'b1111;
                mem_wdata_o = wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            memop_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            memop_q  <= memop_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign lsu_rvalid_o = rvalid_q;
    assign lsu_rdata_o  = rdata_q;

endmodule
